// File: rtl/glip_uart_rx_sampler.sv
// -----------------------------------------------------------------------------
// glip_uart_rx_sampler
//
// 8N1 UART receive front end. Synchronises the raw serial line, qualifies the
// start bit at its centre, samples each data bit at its centre (LSB first),
// and checks the stop bit. A good frame produces a one-cycle `enable` strobe
// with the byte on `data`; a stop bit sampled low produces a one-cycle `error`
// strobe instead, after which the receiver waits for the line to return high
// before it looks for another start bit. There is no backpressure: the line
// rate limits delivery to one byte per 10*DIVISOR cycles.
//
// Optional feature (macro GLIP_UART_RX_MAJORITY_EN):
//   defined   - every decision is a 2-of-3 vote over the synchronised line at
//               nominal point -1, 0 and +1; the decision is taken one cycle
//               after the nominal point.
//   undefined - every decision is a single sample at the nominal point.
//
// Parameters:
//   DIVISOR  clock cycles per bit (FREQ/BAUD), must be >= 8
//
// Ports:
//   clk      in   I/O clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   rx       in   raw serial line, asynchronous to clk, idle high
//   data     out  [7:0] received byte, valid only while enable = 1
//   enable   out  one-cycle strobe: byte received with good stop bit
//   error    out  one-cycle strobe: framing error (stop bit sampled low)
// -----------------------------------------------------------------------------
module glip_uart_rx_sampler #(
  parameter int unsigned DIVISOR = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] data,
  output logic       enable,
  output logic       error
);

  localparam int unsigned CW   = $clog2(DIVISOR);
  localparam int unsigned HALF = DIVISOR / 2;

`ifdef GLIP_UART_RX_MAJORITY_EN
  // The vote needs the sample one cycle past the nominal point.
  localparam int unsigned START_PT = HALF + 1;
`else
  localparam int unsigned START_PT = HALF;
`endif

  // The start decision re-clears the counter, so every later decision sits
  // exactly DIVISOR cycles after the previous one at count DIVISOR-1.
  localparam logic [CW-1:0] START_CNT = CW'(START_PT);
  localparam logic [CW-1:0] BIT_CNT   = CW'(DIVISOR - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [1:0]    r_sync;
  logic          w_rxs;
  logic          w_sample;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic [7:0]    r_data;
  logic          r_enable;
  logic          r_error;
  logic          w_hit;
  logic          w_cnt_clr;
  logic          w_shift;
  logic          w_enable_nxt;
  logic          w_error_nxt;

  // ---------------------------------------------------------------------------
  // Two-flop synchroniser; resets to the idle (high) line level so that reset
  // release never looks like a start bit.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of its neighbours; blocking here would collapse the chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= 2'b11;
    end else begin
      r_sync <= {r_sync[0], rx};
    end
  end

  assign w_rxs = r_sync[1];

`ifdef GLIP_UART_RX_MAJORITY_EN
  // History of the two previous synchronised samples. At a decision cycle
  // (nominal + 1) the window is {nominal - 1, nominal, nominal + 1}.
  logic [1:0] r_hist;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hist <= 2'b11;
    end else begin
      r_hist <= {r_hist[0], w_rxs};
    end
  end

  assign w_sample = (r_hist[1] & r_hist[0]) |
                    (r_hist[1] & w_rxs)     |
                    (r_hist[0] & w_rxs);
`else
  assign w_sample = w_rxs;
`endif

  // Decision point for the current state.
  assign w_hit = ((r_state == S_START) && (r_cnt == START_CNT)) ||
                 (((r_state == S_DATA) || (r_state == S_STOP)) && (r_cnt == BIT_CNT));

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (!w_rxs) w_state_nxt = S_START;
      // A high sample at the start centre is a glitch: drop it silently.
      S_START: if (w_hit)  w_state_nxt = w_sample ? S_IDLE : S_DATA;
      S_DATA:  if (w_hit && (r_bit == 3'd7)) w_state_nxt = S_STOP;
      S_STOP:  if (w_hit)  w_state_nxt = w_sample ? S_IDLE : S_BREAK;
      // Stay here while the line is held low so a break is not re-read as
      // a fresh start bit.
      S_BREAK: if (w_rxs)  w_state_nxt = S_IDLE;
      default:             w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: output / control logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_cnt_clr    = 1'b0;
    w_shift      = 1'b0;
    w_enable_nxt = 1'b0;
    w_error_nxt  = 1'b0;
    case (r_state)
      S_IDLE:  w_cnt_clr = 1'b1;
      S_START: w_cnt_clr = w_hit;
      S_DATA: begin
        w_cnt_clr = w_hit;
        w_shift   = w_hit;
      end
      S_STOP: begin
        w_cnt_clr    = w_hit;
        w_enable_nxt = w_hit & w_sample;
        w_error_nxt  = w_hit & ~w_sample;
      end
      S_BREAK: w_cnt_clr = 1'b1;
      default: w_cnt_clr = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: bit-period counter, bit index, shift register, output strobes.
  // The shift register is separate from `data` so the output only changes
  // when a good frame is delivered.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_bit    <= 3'd0;
      r_shift  <= 8'h00;
      r_data   <= 8'h00;
      r_enable <= 1'b0;
      r_error  <= 1'b0;
    end else begin
      r_cnt <= w_cnt_clr ? '0 : r_cnt + CW'(1);

      if ((r_state == S_START) && w_hit) begin
        r_bit <= 3'd0;
      end else if (w_shift) begin
        r_bit <= r_bit + 3'd1;
      end

      if (w_shift) begin
        r_shift <= {w_sample, r_shift[7:1]};
      end

      if (w_enable_nxt) begin
        r_data <= r_shift;
      end

      r_enable <= w_enable_nxt;
      r_error  <= w_error_nxt;
    end
  end

  assign data   = r_data;
  assign enable = r_enable;
  assign error  = r_error;

endmodule
